// File: rtl/gate_arb_seq.sv
// rtl/gate_arb_seq.sv - two-requester round-robin arbiter sharing one bitwise gate evaluator
// Optional GATE_ARB_SEQ_PARALLEL_EN: evaluate all bits in one EVAL edge instead of bit-serially.
module gate_arb_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result0,
  output logic [WIDTH-1:0] result1,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic             win;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] full;

  function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  gate_eval = a & b;
      3'b001:  gate_eval = a | b;
      3'b010:  gate_eval = ~a;
      3'b011:  gate_eval = ~(a & b);
      3'b100:  gate_eval = ~(a | b);
      3'b101:  gate_eval = a ^ b;
      3'b110:  gate_eval = ~(a ^ b);
      default: gate_eval = '0;
    endcase
  endfunction

  // Tie goes to whichever requester was not served last.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = ~last;
    else if (req1)    win = 1'b1;
  end

  assign full = gate_eval(op_q, a_q, b_q);

`ifndef GATE_ARB_SEQ_PARALLEL_EN
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] next_acc;

  always_comb begin
    next_acc      = acc;
    next_acc[idx] = full[idx];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      result0 <= '0;
      result1 <= '0;
`ifndef GATE_ARB_SEQ_PARALLEL_EN
      idx     <= '0;
      acc     <= '0;
`endif
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= win;
            last  <= win;
            op_q  <= win ? op1 : op0;
            a_q   <= win ? a1 : a0;
            b_q   <= win ? b1 : b0;
            gnt0  <= ~win;
            gnt1  <= win;
            busy  <= 1'b1;
            state <= EVAL;
`ifndef GATE_ARB_SEQ_PARALLEL_EN
            idx   <= '0;
            acc   <= '0;
`endif
          end
        end
        EVAL: begin
`ifdef GATE_ARB_SEQ_PARALLEL_EN
          state <= DONE;
          err   <= (op_q == 3'b111);
          if (owner) begin
            result1 <= full;
            done1   <= 1'b1;
          end else begin
            result0 <= full;
            done0   <= 1'b1;
          end
`else
          acc <= next_acc;
          idx <= idx + 1'b1;
          if (idx == IW'(WIDTH - 1)) begin
            state <= DONE;
            err   <= (op_q == 3'b111);
            if (owner) begin
              result1 <= next_acc;
              done1   <= 1'b1;
            end else begin
              result0 <= next_acc;
              done0   <= 1'b1;
            end
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_arb_seq.sv
// tb/tb_gate_arb_seq.sv - self-checking bench for gate_arb_seq (table vectors + scoreboard)
module tb_gate_arb_seq;

`ifdef GATE_ARB_SEQ_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 8;
`endif

  logic       clk = 0;
  logic       rst;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1, err, busy;
  logic [7:0] result0, result1;

  gate_arb_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .result0(result0), .result1(result1),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       e;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       e;
  } sb_t;

  sb_t        sb[$];
  vec_t       vecs[12];
  int         nchk = 0;
  int         nfail = 0;
  logic [7:0] exp_res[2];
  logic       exp_err[2];
  logic [7:0] model[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      nchk++;
      if ((gnt0 && gnt1) || (done0 && done1)) begin
        nfail++;
        $display("FAIL exclusive: gnt=%b%b done=%b%b expected at most one each", gnt1, gnt0, done1, done0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] res, input logic e);
    exp_res[id] = res;
    exp_err[id] = e;
    if (id == 0) begin op0 = op; a0 = a; b0 = b; req0 = 1; end
    else         begin op1 = op; a1 = a; b1 = b; req1 = 1; end
  endtask

  task automatic await_grant(input int id, input int exp_wait, input bit keep);
    int n = 0;
    bit got = 0;
    while (!got && n < 40) begin
      step();
      n++;
      if (gnt0 || gnt1) got = 1;
    end
    chk("grant_seen", got, 1);
    if (got) begin
      chk("gnt_owner", (id == 1) ? gnt1 : gnt0, 1);
      chk("gnt_other", (id == 1) ? gnt0 : gnt1, 0);
      chk("busy_at_gnt", busy, 1);
      if (exp_wait > 0) chk("grant_wait", n, exp_wait);
      sb.push_back('{id: id, res: exp_res[id], e: exp_err[id]});
      if (id == 0) begin
        a0 = 8'h00; b0 = 8'h00;
        if (!keep) req0 = 0;
      end else begin
        a1 = 8'h00; b1 = 8'h00;
        if (!keep) req1 = 0;
      end
    end
  endtask

  task automatic await_done(input int id);
    int  n = 0;
    bit  got = 0;
    bit  quiet = 1;
    sb_t e;
    while (!got && n < 40) begin
      step();
      n++;
      if (done0 || done1) got = 1;
      else if (err || gnt0 || gnt1) quiet = 0;
    end
    chk("done_seen", got, 1);
    chk("quiet_in_eval", quiet, 1);
    if (got) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("latency", n, LAT);
        chk("done_owner", (e.id == 1) ? done1 : done0, 1);
        chk("done_other", (e.id == 1) ? done0 : done1, 0);
        chk("result", (e.id == 1) ? result1 : result0, e.res);
        chk("err", err, e.e);
        chk("other_held", (e.id == 1) ? result0 : result1, model[1 - e.id]);
        chk("busy_at_done", busy, 1);
        model[e.id] = e.res;
      end
      step();
      chk("busy_after_done", busy, 0);
      chk("done_cleared", done0 | done1 | err, 0);
    end
  endtask

  task automatic apply_reset();
    rst = 1;
    req0 = 0; req1 = 0;
    step();
    step();
    rst = 0;
    sb.delete();
    model[0] = 0;
    model[1] = 0;
  endtask

  initial begin
    rst = 1; req0 = 0; req1 = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    model[0] = 0; model[1] = 0;

    vecs[0]  = '{0, 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1]  = '{1, 3'b000, 8'hC5, 8'h5A, 8'h40, 1'b0};
    vecs[2]  = '{1, 3'b001, 8'hC5, 8'h5A, 8'hDF, 1'b0};
    vecs[3]  = '{1, 3'b010, 8'hC5, 8'h5A, 8'h3A, 1'b0};
    vecs[4]  = '{1, 3'b011, 8'hC5, 8'h5A, 8'hBF, 1'b0};
    vecs[5]  = '{1, 3'b100, 8'hC5, 8'h5A, 8'h20, 1'b0};
    vecs[6]  = '{1, 3'b101, 8'hC5, 8'h5A, 8'h9F, 1'b0};
    vecs[7]  = '{1, 3'b110, 8'hC5, 8'h5A, 8'h60, 1'b0};
    vecs[8]  = '{1, 3'b111, 8'hC5, 8'h5A, 8'h00, 1'b1};
    vecs[9]  = '{0, 3'b010, 8'h00, 8'hFF, 8'hFF, 1'b0};
    vecs[10] = '{0, 3'b101, 8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[11] = '{0, 3'b100, 8'h81, 8'h18, 8'h66, 1'b0};

    apply_reset();
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result0", result0, 0);
    chk("rst_result1", result1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].e);
      await_grant(vecs[i].id, 1, 0);
      await_done(vecs[i].id);
    end

    // Tie from reset: requester 0 first, requester 1 after one idle cycle.
    apply_reset();
    drive(0, 3'b110, 8'hAA, 8'h0F, 8'h5A, 1'b0);
    drive(1, 3'b011, 8'hFF, 8'h81, 8'h7E, 1'b0);
    await_grant(0, 1, 0);
    await_done(0);
    await_grant(1, 1, 0);
    await_done(1);

    // Reset in the middle of a job aborts it.
    drive(0, 3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    await_grant(0, 1, 0);
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    chk("abort_done", {done1, done0}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result0", result0, 0);
    chk("abort_result1", result1, 0);
    sb.delete();
    model[0] = 0; model[1] = 0;
    begin
      bit seen = 0;
      for (int c = 0; c < 12; c++) begin
        step();
        if (done0 || done1 || busy) seen = 1;
      end
      chk("abort_no_done", seen, 0);
    end
    drive(0, 3'b001, 8'h12, 8'h40, 8'h52, 1'b0);
    drive(1, 3'b101, 8'h0F, 8'hF0, 8'hFF, 1'b0);
    await_grant(0, 1, 0);
    await_done(0);
    await_grant(1, 1, 0);
    await_done(1);

    // Requester 1 holds req high, requester 0 pulses: service 1, 0, 1.
    drive(1, 3'b000, 8'h3C, 8'h0F, 8'h0C, 1'b0);
    await_grant(1, 1, 1);
    drive(0, 3'b011, 8'hF0, 8'hF0, 8'h0F, 1'b0);
    drive(1, 3'b001, 8'h01, 8'h80, 8'h81, 1'b0);
    await_done(1);
    await_grant(0, 1, 0);
    await_done(0);
    await_grant(1, 1, 0);
    await_done(1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
